event_packet_uart_tx: RTL and testbench
=======================================

EVENT_PACKET_UART_TX -- requirements
Module: event_packet_uart_tx

Interface
REQ-001 Parameter CLK_HZ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate.
REQ-003 Parameter NBYTES, default 4, bytes per event packet.
REQ-004 clk  input  1  system clock; all logic on posedge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 new_tx  input  1  single-cycle packet start request from the TX generator stage.
REQ-007 data_in  input  8*NBYTES  event packet word, sampled only on an accepted new_tx.
REQ-008 tx  output  1  UART serial line, 8N1, idle high.
REQ-009 busy  output  1  high from acceptance until the last stop bit completes.
REQ-010 tx_done  output  1  single-cycle pulse when a packet is fully sent; fed back to the TX generator.

Function
REQ-011 CLKS_PER_BIT SHALL equal CLK_HZ/BAUD (integer division); every start, data and stop bit SHALL last exactly CLKS_PER_BIT clocks.
REQ-012 The state machine SHALL have states IDLE, START, DATA, STOP; IDLE->START on accepted new_tx, START->DATA after one bit time, DATA->STOP after 8 bits, STOP->START if bytes remain, STOP->IDLE after the last byte.
REQ-013 new_tx SHALL be accepted only in IDLE; new_tx in any other state SHALL be ignored with no side effects.
REQ-014 On acceptance data_in SHALL be latched; later data_in changes SHALL NOT affect the packet in flight.
REQ-015 tx SHALL go low on the clock edge that accepts new_tx (one-cycle latency).
REQ-016 Byte order: data_in[7:0] first, then ascending bytes; bit order within a byte LSB first.
REQ-017 No idle gap SHALL be inserted between bytes of a packet: next start bit follows the stop bit immediately.
REQ-018 tx_done SHALL be high for exactly one clock, in the first IDLE cycle after the final stop bit, exactly NBYTES*10*CLKS_PER_BIT clocks after tx first falls.
REQ-019 A new_tx arriving in the same cycle as tx_done SHALL be accepted (supports new_tx = tx_done loop-back); line then stays high for exactly one clock between packets.
REQ-020 busy SHALL be high in START, DATA, STOP and low in IDLE.
REQ-021 Bit-period counter SHALL be $clog2(CLKS_PER_BIT) bits wide, byte index $clog2(NBYTES) (min 1) bits, bit index 3 bits; counters SHALL wrap only by explicit reload, never by overflow.
REQ-022 CLKS_PER_BIT < 2 or NBYTES < 1 SHALL be rejected at elaboration.

Reset
REQ-023 While rst_n is low: state IDLE, tx=1, busy=0, tx_done=0, all counters and the data latch zero.
REQ-024 Reset assertion mid-packet SHALL abort immediately, drive tx high asynchronously, and produce no tx_done.
REQ-025 After rst_n rises, the first new_tx SHALL be accepted normally.

Structure
REQ-026 A shared package SHALL hold the state enum and the CLKS_PER_BIT calculation function.
REQ-027 One sub-module, uart_byte_tx (single-byte 8N1 serializer with start/done handshake), SHALL be instantiated under the packet sequencer.

Verification (CLK_HZ=1000, BAUD=100, CLKS_PER_BIT=10, NBYTES=4)
REQ-028 Reset: rst_n low 5 clocks -> tx=1, busy=0, tx_done=0 throughout and after release.
REQ-029 Single packet: new_tx with data_in=0xA53C0F81 -> bytes 0x81,0x0F,0x3C,0xA5 LSB-first on tx, 400 clocks of framing, tx_done one pulse 400 clocks after tx falls.
REQ-030 Busy ignore: extra new_tx at clock 150 with data_in=0xFFFFFFFF -> serial output unchanged, one tx_done only.
REQ-031 Loop-back: new_tx = tx_done OR one external pulse -> back-to-back packets, tx high exactly 1 clock between stop and next start, identical data repeated.
REQ-032 Mid-packet reset at clock 123 -> tx=1 same cycle, busy=0, no tx_done; subsequent packet 0x00000001 transmitted correctly.

Source files
------------

// File: rtl/event_packet_uart_tx_pkg.sv
// Shared types and helpers for the event packet UART transmitter.
package event_packet_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  function automatic int unsigned calc_clks_per_bit(input int unsigned clk_hz,
                                                    input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/event_packet_uart_tx_byte.sv
// Single-byte 8N1 serializer. A start_i seen on the final stop-bit clock chains
// straight into the next start bit with no idle gap.
module uart_byte_tx
  import event_packet_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          tick;

  assign tick   = (cnt_q == CNT_MAX);
  assign tx_o   = tx_q;
  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == STOP) && tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  // tx is registered, so each branch sets tx_d to the level of the bit being entered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (start_i) begin
          state_d = START;
          cnt_d   = '0;
          shreg_d = data_i;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shreg_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (tick) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            bit_d   = '0;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          cnt_d = '0;
          if (start_i) begin
            state_d = START;
            shreg_d = data_i;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/event_packet_uart_tx.sv
// Packet sequencer: latches an NBYTES event word and streams it LSB byte first
// through the byte serializer, pulsing tx_done once the last stop bit ends.
module event_packet_uart_tx
  import event_packet_uart_tx_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100000000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  new_tx,
  input  logic [8*NBYTES-1:0]   data_in,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  if (CLKS_PER_BIT < 2 || NBYTES < 1) begin : g_bad_cfg
    $error("event_packet_uart_tx: CLKS_PER_BIT must be >= 2 and NBYTES >= 1");
  end

  logic [8*NBYTES-1:0] data_q, data_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [IW-1:0]       next_idx;
  logic                done_q, done_d;
  logic                byte_start;
  logic [7:0]          byte_data;
  logic                byte_busy;
  logic                byte_done;
  logic                accept;

  assign accept   = new_tx && !byte_busy;
  assign next_idx = idx_q + 1'b1;
  assign busy     = byte_busy;
  assign tx_done  = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      idx_q  <= '0;
      done_q <= 1'b0;
    end else begin
      data_q <= data_d;
      idx_q  <= idx_d;
      done_q <= done_d;
    end
  end

  // The first byte comes straight from data_in so tx can fall on the accepting edge.
  always_comb begin
    data_d     = data_q;
    idx_d      = idx_q;
    done_d     = 1'b0;
    byte_start = 1'b0;
    byte_data  = '0;
    if (accept) begin
      data_d     = data_in;
      idx_d      = '0;
      byte_start = 1'b1;
      byte_data  = data_in[7:0];
    end else if (byte_done) begin
      if (idx_q != LAST_IDX) begin
        idx_d      = next_idx;
        byte_start = 1'b1;
        byte_data  = data_q[{next_idx, 3'b000} +: 8];
      end else begin
        done_d = 1'b1;
      end
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(byte_start),
    .data_i (byte_data),
    .tx_o   (tx),
    .busy_o (byte_busy),
    .done_o (byte_done)
  );

endmodule

// File: tb/tb_event_packet_uart_tx.sv
// Directed bench for event_packet_uart_tx at 10 clocks per bit, 4-byte packets.
module tb_event_packet_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        new_tx;
  logic        new_tx_drv;
  logic        loop_en;
  logic [31:0] data_in;
  logic        tx;
  logic        busy;
  logic        tx_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign new_tx = new_tx_drv | (loop_en & tx_done);

  event_packet_uart_tx #(
    .CLK_HZ(1000),
    .BAUD  (100),
    .NBYTES(4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .new_tx (new_tx),
    .data_in(data_in),
    .tx     (tx),
    .busy   (busy),
    .tx_done(tx_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Ends on the first negedge after the accepting posedge (negedge 0 of the packet).
  task automatic pulse(input logic [31:0] d);
    @(negedge clk);
    new_tx_drv = 1'b1;
    data_in    = d;
    @(negedge clk);
    new_tx_drv = 1'b0;
  endtask

  // Called at negedge 0; samples mid-bit and returns at negedge 400.
  task automatic capture(input logic [31:0] exp, input string tag, input int inject_at);
    logic [31:0] word;
    int ferr, dcnt, dat, f, pos, b;
    word = '0; ferr = 0; dcnt = 0; dat = -1;
    check({tag, "_start"}, {29'd0, tx, busy, tx_done}, 32'b010);
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (n == inject_at) begin
        new_tx_drv = 1'b1;
        data_in    = 32'hFFFF_FFFF;
      end else if (n == inject_at + 1) begin
        new_tx_drv = 1'b0;
      end
      if (tx_done) begin
        dcnt++;
        dat = n;
      end
      if (n == 200) check({tag, "_busy_mid"}, {31'd0, busy}, 32'd1);
      if (n % 10 == 5) begin
        f   = n / 10;
        pos = f % 10;
        b   = f / 10;
        if (pos == 0) begin
          if (tx !== 1'b0) ferr++;
        end else if (pos == 9) begin
          if (tx !== 1'b1) ferr++;
        end else begin
          word[b*8 + pos - 1] = tx;
        end
      end
    end
    check({tag, "_data"}, word, exp);
    check({tag, "_framing"}, ferr, 0);
    check({tag, "_done_cnt"}, dcnt, 1);
    check({tag, "_done_at"}, dat, 400);
    check({tag, "_idle_at_done"}, {30'd0, tx, busy}, 32'b10);
  endtask

  initial begin
    int dcount;
    rst_n      = 1'b0;
    new_tx_drv = 1'b0;
    loop_en    = 1'b0;
    data_in    = '0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_hold", {29'd0, tx, busy, tx_done}, 32'b100);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset_release", {29'd0, tx, busy, tx_done}, 32'b100);
    end

    pulse(32'hA53C_0F81);
    data_in = 32'h0000_0000;
    capture(32'hA53C_0F81, "pkt1", -1);
    @(negedge clk);
    check("pkt1_after", {29'd0, tx_done, tx, busy}, 32'b010);

    pulse(32'h1234_5678);
    capture(32'h1234_5678, "busy_ign", 150);
    @(negedge clk);
    check("busy_ign_after", {29'd0, tx_done, tx, busy}, 32'b010);

    loop_en = 1'b1;
    pulse(32'h5AC3_0FF0);
    capture(32'h5AC3_0FF0, "loop1", -1);
    check("loop_gap_high", {31'd0, tx}, 32'd1);
    @(negedge clk);
    capture(32'h5AC3_0FF0, "loop2", -1);
    loop_en = 1'b0;
    @(negedge clk);
    check("loop_end", {29'd0, tx_done, tx, busy}, 32'b010);

    pulse(32'h0000_0000);
    for (int n = 1; n <= 123; n++) @(negedge clk);
    check("abort_pre", {30'd0, tx, busy}, 32'b01);
    rst_n = 1'b0;
    #1;
    check("abort_async", {29'd0, tx, busy, tx_done}, 32'b100);
    dcount = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (tx_done) dcount++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (tx_done) dcount++;
    end
    check("abort_no_done", dcount, 0);
    check("abort_idle", {30'd0, tx, busy}, 32'b10);

    pulse(32'h0000_0001);
    capture(32'h0000_0001, "post_rst", -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
